// File: rtl/prio_event_encoder.sv
// prio_event_encoder: sticky request capture with a registered priority
// selection (fixed or round-robin) presented over a valid/ready handshake.
// Overflow on re-request of an already-pending line is pulsed and counted.
module prio_event_encoder #(
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 3,
  parameter int RR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending,
  output logic             overflow,
  output logic [7:0]       ovf_cnt
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] ZERO_I = {IDX_W{1'b0}};
  localparam logic             ST_IDLE    = 1'b0;
  localparam logic             ST_PRESENT = 1'b1;

  // Fixed priority: the highest set index wins.
  function automatic logic [IDX_W-1:0] sel_fixed(input logic [WIDTH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = ZERO_I;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Round-robin: descend from start-1, wrap 0 -> WIDTH-1, finish at start.
  function automatic logic [IDX_W-1:0] sel_rr(input logic [WIDTH-1:0] vec,
                                              input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pos_w;
    logic             found;
    int               pos;
    idx   = ZERO_I;
    found = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      pos = int'(start) - k;
      if (pos < 0) begin
        pos = pos + WIDTH;
      end
      pos_w = IDX_W'(pos);
      if (!found && vec[pos_w]) begin
        found = 1'b1;
        idx   = pos_w;
      end
    end
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] sel_idx(input logic [WIDTH-1:0] vec,
                                               input logic [IDX_W-1:0] start);
    if (RR_MODE != 0) begin
      return sel_rr(vec, start);
    end else begin
      return sel_fixed(vec);
    end
  endfunction

  logic             out_valid_r;
  logic [IDX_W-1:0] out_idx_r;
  logic [IDX_W-1:0] last_r;
  logic [WIDTH-1:0] pending_r;
  logic             overflow_r;
  logic [7:0]       ovf_cnt_r;

  logic             hs_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] cap_s;
  logic [WIDTH-1:0] pending_nxt_s;
  logic             ovf_hit_s;
  logic [7:0]       ovf_cnt_nxt_s;
  logic             valid_nxt_s;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [IDX_W-1:0] last_nxt_s;

  // Handshake, clear mask, next pending value and overflow detection.
  always_comb begin
    hs_s = out_valid_r & out_ready;
    if (hs_s) begin
      clr_s = ONE_W << out_idx_r;
    end else begin
      clr_s = ZERO_W;
    end
    rem_s = pending_r & ~clr_s;
    if (en) begin
      cap_s = req_in;
    end else begin
      cap_s = ZERO_W;
    end
    pending_nxt_s = rem_s | cap_s;
    ovf_hit_s     = en & (|(req_in & pending_r & ~clr_s));
    if (ovf_hit_s && (ovf_cnt_r != 8'hFF)) begin
      ovf_cnt_nxt_s = ovf_cnt_r + 8'd1;
    end else begin
      ovf_cnt_nxt_s = ovf_cnt_r;
    end
  end

  // Next-state logic: out_valid is the FSM state (IDLE / PRESENT).
  always_comb begin
    valid_nxt_s = out_valid_r;
    case (out_valid_r)
      ST_IDLE: begin
        if (pending_r != ZERO_W) begin
          valid_nxt_s = ST_PRESENT;
        end else begin
          valid_nxt_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (hs_s && (rem_s == ZERO_W)) begin
          valid_nxt_s = ST_IDLE;
        end else begin
          valid_nxt_s = ST_PRESENT;
        end
      end
      default: valid_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: index to present next and round-robin pointer update.
  // On a handshake the line being consumed becomes the new search origin.
  always_comb begin
    idx_nxt_s  = out_idx_r;
    last_nxt_s = last_r;
    case (out_valid_r)
      ST_IDLE: begin
        if (pending_r != ZERO_W) begin
          idx_nxt_s = sel_idx(pending_r, last_r);
        end else begin
          idx_nxt_s = out_idx_r;
        end
      end
      ST_PRESENT: begin
        if (hs_s) begin
          last_nxt_s = out_idx_r;
          if (rem_s != ZERO_W) begin
            idx_nxt_s = sel_idx(rem_s, out_idx_r);
          end else begin
            idx_nxt_s = out_idx_r;
          end
        end else begin
          idx_nxt_s = out_idx_r;
        end
      end
      default: begin
        idx_nxt_s  = ZERO_I;
        last_nxt_s = ZERO_I;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= ST_IDLE;
    end else begin
      out_valid_r <= valid_nxt_s;
    end
  end

  // Datapath registers: index, pointer, pending set and overflow tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_idx_r  <= ZERO_I;
      last_r     <= ZERO_I;
      pending_r  <= ZERO_W;
      overflow_r <= 1'b0;
      ovf_cnt_r  <= 8'd0;
    end else begin
      out_idx_r  <= idx_nxt_s;
      last_r     <= last_nxt_s;
      pending_r  <= pending_nxt_s;
      overflow_r <= ovf_hit_s;
      ovf_cnt_r  <= ovf_cnt_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign pending   = pending_r;
  assign overflow  = overflow_r;
  assign ovf_cnt   = ovf_cnt_r;

endmodule

// File: doc/prio_event_encoder.md
# prio_event_encoder

Parametrised, registered successor to the team's combinational 8-to-3 priority encoder. Captures single-cycle request pulses on `WIDTH` lines into a sticky pending register and emits the winning line as a binary index over a valid/ready handshake, clearing each line once it is consumed. The arbitration mode is selectable between fixed priority and round-robin. Overflow is flagged and counted. The block sits between interrupt/event sources and a single consumer.

## Interface
- `WIDTH`, 8: number of request lines, from 2 to 64.
- `IDX_W`, 3: index width; must equal `$clog2(WIDTH)`.
- `RR_MODE`, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `en` input 1: capture enable; while low, `req_in` is ignored.
- `req_in` input WIDTH: request pulses, OR-ed into `pending`.
- `out_ready` input 1: consumer accepts `out_idx` this cycle.
- `out_valid` output 1: `out_idx` holds a pending line.
- `out_idx` output IDX_W: binary index of the presented line.
- `pending` output WIDTH: current sticky request register.
- `overflow` output 1: one-cycle pulse when a request hits an already-pending line.
- `ovf_cnt` output 8: saturating count of overflow events.

## Operation
- Handshake: `hs = out_valid & out_ready`. `clr` is the one-hot of `out_idx` when `hs` is high, else 0.
- Pending update: `pending <= (pending & ~clr) | (en ? req_in : 0)`. When a line is cleared and re-requested in the same cycle, the line stays set. This case is not an overflow.
- Overflow: `ovf_hit = en & |(req_in & pending & ~clr)`. It registers into `overflow` on the next cycle. `ovf_cnt` increments by 1 per hit cycle, regardless of how many bits hit, and saturates at 255.
- Output FSM, with `out_valid` as the state:
  - IDLE (`out_valid`=0): if `pending != 0`, load `out_idx = sel(pending)` and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT (`out_valid`=1): hold `out_idx` stable while `out_ready`=0. A higher-priority arrival does not preempt the presented line.
  - On `hs`, set `rem = pending & ~clr`. If `rem != 0`, load `out_idx = sel(rem)` and stay in PRESENT. Otherwise go to IDLE.
  - `req_in` arriving in the `hs` cycle is not visible to that selection. It joins `pending` and competes on a later cycle.
- `sel()` in fixed mode (`RR_MODE`=0): the highest set index wins.
- `sel()` in round-robin mode (`RR_MODE`=1):
  - `last` is a register holding the most recently handshaken index.
  - The search descends from `last-1`, wraps from 0 to `WIDTH-1`, and ends at `last`.
  - `last` is updated only on `hs`.
  - Reset value of `last` is 0, so the first search starts at `WIDTH-1`. This is identical to fixed mode.
- `en` low freezes capture only. Draining and handshakes continue.
- The presented line's bit stays set in `pending` until its handshake.

## Timing
- Reset values (applied on any edge with `rst_n`=0, including mid-operation): `pending`=0, `out_valid`=0, `out_idx`=0, `overflow`=0, `ovf_cnt`=0, `last`=0. Any in-flight presentation is dropped.
- Latency from IDLE: a pulse on `req_in` at edge t sets `pending` at t+1 and sets `out_valid` with `out_idx` at t+2.
- Throughput: one index per cycle while `out_ready`=1 and `rem != 0`. There are no bubbles.
- `overflow` is high for exactly one cycle, the cycle after the offending request. `ovf_cnt` updates on the same edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Fixed drain: `WIDTH`=8, `RR_MODE`=0, `out_ready`=1. Pulse `req_in`=0xA4 at cycle 0. Required response:
  - `out_valid`=1 during cycles 2–4, with `out_idx` = 7, 5, 2 on cycles 2, 3, 4.
  - `out_valid`=0 from cycle 5.
  - `pending`=0 from cycle 5.
- Backpressure, no preemption: `out_ready`=0. Pulse 0x05, then pulse 0x80 two cycles later. Required response:
  - `out_idx` stays 2 (`out_valid`=1) while `out_ready`=0, with `pending`=0x85.
  - After `out_ready` is raised, the order is 2, then 7, then 0.
- Round-robin: `RR_MODE`=1, `out_ready`=1. Pulse 0x84, drain it, then pulse 0x09. Required response:
  - The first drain gives 7, then 2, leaving `last`=2.
  - The 0x09 drain gives 0, then 3.
  - The same stimulus with `RR_MODE`=0 gives 3, then 0.
- Overflow: `out_ready`=0, pulse 0x10 at cycle 0 and again at cycle 3. Required response:
  - `overflow`=1 only at cycle 4, and `ovf_cnt`=1.
  - Exactly one grant of index 4 follows once `out_ready` is raised.
- Clear/re-request collision: a handshake of idx 4 occurs with `req_in`=0x10 in the same cycle and `pending`=0x10. Required response:
  - `overflow` stays 0 and `pending` stays 0x10.
  - `out_valid` drops for one cycle, then idx 4 is presented again.
- Enable and reset: `en`=0 with a pulse of 0xFF leaves `pending`=0. Asserting `rst_n`=0 while PRESENT with `pending`=0x0F gives all outputs 0 on the next edge, and `ovf_cnt`=0.
